// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_mem
// Purpose  : AXI slave backed by a MEM_WORDS x DW on-chip memory. Independent
//            write (AW/W/B) and read (AR/R) state machines, FIXED/INCR/WRAP
//            bursts, byte strobes, SLVERR on unsupported bursts or bad W_LAST.
// Ports    : HCLK, HRESETn (async, active-low)
//            AW : axi_aw_{id,addr,len,size,burst,valid}_i, axi_aw_ready_o
//            W  : axi_w_{data,strb,last,valid}_i, axi_w_ready_o
//            B  : axi_b_{id,resp,valid}_o, axi_b_ready_i
//            AR : axi_ar_{id,addr,len,size,burst,valid}_i, axi_ar_ready_o
//            R  : axi_r_{id,data,resp,last,valid}_o, axi_r_ready_i
// Revision : 1.0 - initial release
// ============================================================================
module axi_slave_mem #(
  parameter int DW        = 64,
  parameter int AW        = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            axi_aw_id_i,
  input  logic [AW-1:0]   axi_aw_addr_i,
  input  logic [7:0]      axi_aw_len_i,
  input  logic [2:0]      axi_aw_size_i,
  input  logic [1:0]      axi_aw_burst_i,
  input  logic            axi_aw_valid_i,
  output logic            axi_aw_ready_o,
  input  logic [DW-1:0]   axi_w_data_i,
  input  logic [DW/8-1:0] axi_w_strb_i,
  input  logic            axi_w_last_i,
  input  logic            axi_w_valid_i,
  output logic            axi_w_ready_o,
  output logic            axi_b_id_o,
  output logic [1:0]      axi_b_resp_o,
  output logic            axi_b_valid_o,
  input  logic            axi_b_ready_i,
  input  logic            axi_ar_id_i,
  input  logic [AW-1:0]   axi_ar_addr_i,
  input  logic [7:0]      axi_ar_len_i,
  input  logic [2:0]      axi_ar_size_i,
  input  logic [1:0]      axi_ar_burst_i,
  input  logic            axi_ar_valid_i,
  output logic            axi_ar_ready_o,
  output logic            axi_r_id_o,
  output logic [DW-1:0]   axi_r_data_o,
  output logic [1:0]      axi_r_resp_o,
  output logic            axi_r_last_o,
  output logic            axi_r_valid_o,
  input  logic            axi_r_ready_i
);

  localparam int         c_NB     = DW / 8;
  localparam int         c_OFFW   = $clog2(c_NB);
  localparam int         c_IW     = $clog2(MEM_WORDS);
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // Address of the following beat; WRAP keeps the upper bits of the
  // (len+1)<<size window and lets only the in-window offset roll over.
  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                                 input logic [7:0] ln, input logic [1:0] bt);
    logic [AW-1:0] l_step, l_mask, l_inc;
    l_step = AW'(1) << sz;
    l_mask = ((AW'(ln) + AW'(1)) << sz) - AW'(1);
    l_inc  = a + l_step;
    case (bt)
      2'b00:   return a;
      2'b10:   return (a & ~l_mask) | (l_inc & l_mask);
      default: return l_inc;
    endcase
  endfunction

  function automatic logic f_err(input logic [2:0] sz, input logic [7:0] ln, input logic [1:0] bt);
    return (bt == 2'b11) || (int'(sz) > c_OFFW) ||
           ((bt == 2'b10) && !((ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15)));
  endfunction

  logic [DW-1:0] r_mem [MEM_WORDS];

  // ---------------- write channel ----------------
  wstate_t       r_wstate;
  logic          r_aw_ready, r_w_ready, r_b_valid, r_b_id, r_wid, r_werr, r_wlast_err;
  logic [1:0]    r_b_resp, r_wburst;
  logic [AW-1:0] r_waddr;
  logic [7:0]    r_wlen, r_wcnt;
  logic [2:0]    r_wsize;
  logic          w_wr_en;
  logic [c_IW-1:0] w_widx;

  assign w_wr_en = (r_wstate == W_DATA) && r_w_ready && axi_w_valid_i && !r_werr;
  assign w_widx  = r_waddr[c_OFFW +: c_IW];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wstate <= W_IDLE;  r_aw_ready <= 1'b0; r_w_ready <= 1'b0; r_b_valid <= 1'b0;
      r_b_id   <= 1'b0;    r_b_resp   <= 2'b00; r_wid    <= 1'b0; r_werr    <= 1'b0;
      r_wlast_err <= 1'b0; r_waddr <= '0; r_wlen <= '0; r_wcnt <= '0; r_wsize <= '0;
      r_wburst <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_aw_ready <= 1'b1;
          if (axi_aw_valid_i && r_aw_ready) begin
            r_wid       <= axi_aw_id_i;
            r_waddr     <= axi_aw_addr_i;
            r_wlen      <= axi_aw_len_i;
            r_wsize     <= axi_aw_size_i;
            r_wburst    <= axi_aw_burst_i;
            r_wcnt      <= 8'd0;
            r_werr      <= f_err(axi_aw_size_i, axi_aw_len_i, axi_aw_burst_i);
            r_wlast_err <= 1'b0;
            r_aw_ready  <= 1'b0;
            r_w_ready   <= 1'b1;
            r_wstate    <= W_DATA;
          end
        end
        W_DATA: begin
          if (axi_w_valid_i && r_w_ready) begin
            // Burst length comes from AWLEN only; W_LAST is merely audited.
            if (r_wcnt == r_wlen) begin
              r_w_ready <= 1'b0;
              r_b_valid <= 1'b1;
              r_b_id    <= r_wid;
              r_b_resp  <= (r_werr || r_wlast_err || !axi_w_last_i) ? c_SLVERR : c_OKAY;
              r_wstate  <= W_RESP;
            end else begin
              r_wcnt  <= r_wcnt + 8'd1;
              r_waddr <= f_next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
              if (axi_w_last_i) r_wlast_err <= 1'b1;
            end
          end
        end
        default: begin
          if (axi_b_ready_i) begin
            r_b_valid  <= 1'b0;
            r_b_resp   <= 2'b00;
            r_b_id     <= 1'b0;
            r_aw_ready <= 1'b1;
            r_wstate   <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < c_NB; b++) begin
      if (w_wr_en && axi_w_strb_i[b]) r_mem[w_widx][8*b +: 8] <= axi_w_data_i[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  rstate_t       r_rstate;
  logic          r_ar_ready, r_r_valid, r_r_last, r_r_id, r_rerr;
  logic [1:0]    r_r_resp, r_rburst;
  logic [DW-1:0] r_r_data;
  logic [AW-1:0] r_raddr;
  logic [7:0]    r_rlen, r_rcnt;
  logic [2:0]    r_rsize;
  logic          w_ar_err;
  logic [AW-1:0] w_rnext;

  assign w_ar_err = f_err(axi_ar_size_i, axi_ar_len_i, axi_ar_burst_i);
  assign w_rnext  = f_next_addr(r_raddr, r_rsize, r_rlen, r_rburst);

  // Read data is captured from memory at the handshake edge, so a write to
  // the same word in that cycle is not yet visible (pre-write value).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rstate <= R_IDLE; r_ar_ready <= 1'b0; r_r_valid <= 1'b0; r_r_last <= 1'b0;
      r_r_id   <= 1'b0;   r_rerr     <= 1'b0; r_r_resp  <= 2'b00; r_r_data <= '0;
      r_raddr  <= '0;     r_rlen     <= '0;   r_rcnt    <= '0;    r_rsize  <= '0;
      r_rburst <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_ar_ready <= 1'b1;
          if (axi_ar_valid_i && r_ar_ready) begin
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b1;
            r_r_id     <= axi_ar_id_i;
            r_rerr     <= w_ar_err;
            r_r_resp   <= w_ar_err ? c_SLVERR : c_OKAY;
            r_r_data   <= w_ar_err ? '0 : r_mem[axi_ar_addr_i[c_OFFW +: c_IW]];
            r_r_last   <= (axi_ar_len_i == 8'd0);
            r_rcnt     <= 8'd0;
            r_raddr    <= axi_ar_addr_i;
            r_rlen     <= axi_ar_len_i;
            r_rsize    <= axi_ar_size_i;
            r_rburst   <= axi_ar_burst_i;
            r_rstate   <= R_DATA;
          end
        end
        default: begin
          if (axi_r_ready_i) begin
            if (r_r_last) begin
              r_r_valid  <= 1'b0;
              r_r_last   <= 1'b0;
              r_r_data   <= '0;
              r_r_resp   <= 2'b00;
              r_r_id     <= 1'b0;
              r_ar_ready <= 1'b1;
              r_rstate   <= R_IDLE;
            end else begin
              r_raddr  <= w_rnext;
              r_rcnt   <= r_rcnt + 8'd1;
              r_r_last <= ((r_rcnt + 8'd1) == r_rlen);
              r_r_data <= r_rerr ? '0 : r_mem[w_rnext[c_OFFW +: c_IW]];
            end
          end
        end
      endcase
    end
  end

  assign axi_aw_ready_o = r_aw_ready;
  assign axi_w_ready_o  = r_w_ready;
  assign axi_b_valid_o  = r_b_valid;
  assign axi_b_resp_o   = r_b_resp;
  assign axi_b_id_o     = r_b_id;
  assign axi_ar_ready_o = r_ar_ready;
  assign axi_r_valid_o  = r_r_valid;
  assign axi_r_data_o   = r_r_data;
  assign axi_r_resp_o   = r_r_resp;
  assign axi_r_last_o   = r_r_last;
  assign axi_r_id_o     = r_r_id;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_mem
// Purpose  : Self-checking bench for axi_slave_mem (DW=64). Expected read beats
//            and write responses are queued when stimulus is issued and popped
//            when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_mem;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MW = 256;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic          aw_id = 0, aw_valid = 0, w_last = 0, w_valid = 0, b_ready = 0;
  logic [AW-1:0] aw_addr = 0, ar_addr = 0;
  logic [7:0]    aw_len = 0, ar_len = 0, w_strb = 0;
  logic [2:0]    aw_size = 0, ar_size = 0;
  logic [1:0]    aw_burst = 0, ar_burst = 0;
  logic [DW-1:0] w_data = 0;
  logic          ar_id = 0, ar_valid = 0, r_ready = 0;
  logic          aw_ready, w_ready, b_id, b_valid, ar_ready, r_id, r_last, r_valid;
  logic [1:0]    b_resp, r_resp;
  logic [DW-1:0] r_data;

  axi_slave_mem #(.DW(DW), .AW(AW), .MEM_WORDS(MW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .axi_aw_id_i(aw_id), .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len),
    .axi_aw_size_i(aw_size), .axi_aw_burst_i(aw_burst), .axi_aw_valid_i(aw_valid),
    .axi_aw_ready_o(aw_ready),
    .axi_w_data_i(w_data), .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
    .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready),
    .axi_b_id_o(b_id), .axi_b_resp_o(b_resp), .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready),
    .axi_ar_id_i(ar_id), .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len),
    .axi_ar_size_i(ar_size), .axi_ar_burst_i(ar_burst), .axi_ar_valid_i(ar_valid),
    .axi_ar_ready_o(ar_ready),
    .axi_r_id_o(r_id), .axi_r_data_o(r_data), .axi_r_resp_o(r_resp), .axi_r_last_o(r_last),
    .axi_r_valid_o(r_valid), .axi_r_ready_i(r_ready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [63:0] data; logic [1:0] resp; logic last; logic id;} rbeat_t;
  typedef struct packed {logic [1:0] resp; logic id;} bexp_t;
  rbeat_t rq[$];
  bexp_t  bq[$];
  logic [63:0] model [MW];

  // Reference address sequencing written arithmetically (window base + modulo).
  function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [2:0] sz,
                                           input logic [7:0] ln, input logic [1:0] bt);
    int unsigned step, win, base;
    step = 32'd1 << sz;
    if (bt == 2'b00) return a;
    if (bt == 2'b10) begin
      win  = (int'(ln) + 1) * step;
      base = a - (a % win);
      return base + ((a - base + step) % win);
    end
    return a + step;
  endfunction

  function automatic logic ref_err(input logic [2:0] sz, input logic [7:0] ln, input logic [1:0] bt);
    if (bt == 2'b11 || sz > 3'd3) return 1'b1;
    if (bt == 2'b10 && ln != 1 && ln != 3 && ln != 7 && ln != 15) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Beat i carries d0+i; w_last is asserted on beat last_beat (-1 = never).
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input logic [63:0] d0,
                          input logic [7:0] strb, input int last_beat, input int b_delay);
    logic        err;
    logic [31:0] a;
    bexp_t       e;
    int          t;
    err = ref_err(size, len, burst);
    e.resp = (err || last_beat != int'(len)) ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
    aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id; aw_valid = 1;
    t = 0;
    while (!aw_ready && t < 50) begin tick(); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL aw_timeout aw_ready=%0b want 1", aw_ready); end
    tick();
    aw_valid = 0;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = d0 + 64'(i); w_strb = strb; w_last = (i == last_beat); w_valid = 1;
      t = 0;
      while (!w_ready && t < 50) begin tick(); t++; end
      if (t >= 50) begin checks++; errors++; $display("FAIL w_timeout w_ready=%0b want 1", w_ready); end
      if (!err)
        for (int b = 0; b < 8; b++)
          if (strb[b]) model[a[10:3]][8*b +: 8] = w_data[8*b +: 8];
      a = ref_next(a, size, len, burst);
      tick();
    end
    w_valid = 0; w_last = 0;
    checks++;
    if (b_valid !== 1'b1) begin errors++; $display("FAIL b_valid_latency got %0b want 1", b_valid); end
    for (int k = 0; k < b_delay; k++) begin
      checks++;
      if (b_valid !== 1'b1 || aw_ready !== 1'b0) begin
        errors++; $display("FAIL b_hold b_valid=%0b aw_ready=%0b want 1/0", b_valid, aw_ready);
      end
      tick();
    end
    b_ready = 1;
    e = bq.pop_front();
    checks++;
    if (b_resp !== e.resp || b_id !== e.id) begin
      errors++; $display("FAIL b_resp got resp=%b id=%0b want resp=%b id=%0b", b_resp, b_id, e.resp, e.id);
    end
    tick();
    b_ready = 0;
    checks++;
    if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
      errors++; $display("FAIL b_done b_valid=%0b aw_ready=%0b want 0/1", b_valid, aw_ready);
    end
  endtask

  // Holds r_ready low for stall_cyc cycles when beat stall_beat is presented.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic id, input int stall_beat, input int stall_cyc);
    logic        err;
    logic [31:0] a;
    rbeat_t      e;
    int          t, beat, st;
    err = ref_err(size, len, burst);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = err ? 64'd0 : model[a[10:3]];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      e.id   = id;
      rq.push_back(e);
      a = ref_next(a, size, len, burst);
    end
    ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1;
    t = 0;
    while (!ar_ready && t < 50) begin tick(); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL ar_timeout ar_ready=%0b want 1", ar_ready); end
    tick();
    ar_valid = 0;
    checks++;
    if (r_valid !== 1'b1) begin errors++; $display("FAIL r_valid_latency got %0b want 1", r_valid); end
    beat = 0; t = 0; st = stall_cyc;
    while (beat <= int'(len) && t < 300) begin
      if (r_valid) begin
        if (beat == stall_beat && st > 0) begin
          r_ready = 0;
          checks++;
          if (r_data !== rq[0].data || r_last !== rq[0].last || r_resp !== rq[0].resp) begin
            errors++; $display("FAIL r_stall_stable data=%h want %h", r_data, rq[0].data);
          end
          st--;
        end else begin
          r_ready = 1;
          e = rq.pop_front();
          checks++;
          if (r_data !== e.data || r_resp !== e.resp || r_last !== e.last || r_id !== e.id) begin
            errors++;
            $display("FAIL r_beat%0d got data=%h resp=%b last=%0b id=%0b want data=%h resp=%b last=%0b id=%0b",
                     beat, r_data, r_resp, r_last, r_id, e.data, e.resp, e.last, e.id);
          end
          beat++;
        end
      end
      tick();
      t++;
    end
    if (beat <= int'(len)) begin checks++; errors++; $display("FAIL r_timeout beats=%0d want %0d", beat, len + 1); end
    r_ready = 0;
    checks++;
    if (r_valid !== 1'b0 || r_data !== 64'd0 || ar_ready !== 1'b1) begin
      errors++; $display("FAIL r_done r_valid=%0b r_data=%h ar_ready=%0b want 0/0/1", r_valid, r_data, ar_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if ({aw_ready, w_ready, b_valid, b_resp, b_id, ar_ready, r_valid, r_last, r_resp, r_id} !== 11'd0 ||
        r_data !== 64'd0) begin
      errors++; $display("FAIL reset_outputs aw_ready=%0b ar_ready=%0b r_valid=%0b b_valid=%0b want all 0",
                         aw_ready, ar_ready, r_valid, b_valid);
    end
    HRESETn = 1;
    tick();
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1 || w_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release aw_ready=%0b ar_ready=%0b w_ready=%0b want 1/1/0", aw_ready, ar_ready, w_ready);
    end
  endtask

  task automatic test_incr();
    do_write(32'h10, 8'd3, 3'd3, 2'b01, 1'b1, 64'd1, 8'hFF, 3, 0);
    do_read(32'h10, 8'd3, 3'd3, 2'b01, 1'b1, -1, 0);
  endtask

  task automatic test_wrap();
    do_write(32'h00, 8'd3, 3'd3, 2'b01, 1'b0, 64'h100, 8'hFF, 3, 0);
    do_read(32'h18, 8'd3, 3'd3, 2'b10, 1'b0, -1, 0);   // words 3,0,1,2
    do_read(32'h18, 8'd2, 3'd3, 2'b10, 1'b1, -1, 0);   // illegal wrap length
  endtask

  task automatic test_strb_stall();
    do_write(32'h00, 8'd0, 3'd3, 2'b01, 1'b0, 64'd0, 8'hFF, 0, 0);
    do_write(32'h00, 8'd0, 3'd3, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0);
    do_read(32'h00, 8'd0, 3'd3, 2'b01, 1'b1, 0, 5);
  endtask

  task automatic test_errors();
    do_write(32'h30, 8'd1, 3'd3, 2'b01, 1'b1, 64'hA0, 8'hFF, -1, 3);  // missing w_last
    do_read(32'h30, 8'd1, 3'd3, 2'b01, 1'b0, -1, 0);
    do_write(32'h40, 8'd2, 3'd3, 2'b00, 1'b0, 64'hB0, 8'hFF, 0, 0);   // early w_last, FIXED
    do_read(32'h40, 8'd0, 3'd3, 2'b01, 1'b0, -1, 0);
    do_write(32'h10, 8'd0, 3'd3, 2'b11, 1'b1, 64'hDEAD, 8'hFF, 0, 0); // reserved burst: no write
    do_write(32'h18, 8'd0, 3'd4, 2'b01, 1'b0, 64'hBEEF, 8'hFF, 0, 1); // oversize: no write
    do_read(32'h10, 8'd1, 3'd3, 2'b01, 1'b1, -1, 0);
    do_read(32'h10, 8'd1, 3'd3, 2'b00, 1'b0, 1, 2);
  endtask

  task automatic test_reset_mid_read();
    int t;
    ar_addr = 32'h0; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'b01; ar_id = 1'b1; ar_valid = 1;
    t = 0;
    while (!ar_ready && t < 50) begin tick(); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL ar_timeout ar_ready=%0b want 1", ar_ready); end
    tick();
    ar_valid = 0;
    r_ready = 1;
    checks++;
    if (r_valid !== 1'b1 || r_data !== model[0]) begin
      errors++; $display("FAIL rst_read_beat0 data=%h valid=%0b want %h/1", r_data, r_valid, model[0]);
    end
    tick();
    HRESETn = 0;
    #1;
    checks++;
    if (r_valid !== 1'b0 || r_data !== 64'd0 || r_last !== 1'b0 || ar_ready !== 1'b0 || aw_ready !== 1'b0) begin
      errors++; $display("FAIL rst_immediate r_valid=%0b r_data=%h ar_ready=%0b want 0/0/0", r_valid, r_data, ar_ready);
    end
    r_ready = 0;
    tick();
    tick();
    HRESETn = 1;
    tick();
    checks++;
    if (ar_ready !== 1'b1 || aw_ready !== 1'b1 || r_valid !== 1'b0) begin
      errors++; $display("FAIL rst_release ar_ready=%0b aw_ready=%0b r_valid=%0b want 1/1/0", ar_ready, aw_ready, r_valid);
    end
    do_read(32'h00, 8'd7, 3'd3, 2'b01, 1'b0, -1, 0);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) model[i] = 64'd0;
    test_reset();
    test_incr();
    test_wrap();
    test_strb_stall();
    test_errors();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t want finish", $time);
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter DW, default 64, meaning data bus width in bits (64 or 32).
REQ-002 SHALL have parameter AW, default 32, meaning address width in bits.
REQ-003 SHALL have parameter MEM_WORDS, default 256, meaning number of DW-wide storage words (power of 2).
REQ-004 SHALL have port HCLK  input  1  clock; the block uses one clock, all logic on its rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port axi_aw_id_i  input  1  write ID.
REQ-007 SHALL have port axi_aw_addr_i  input  AW  write start byte address.
REQ-008 SHALL have port axi_aw_len_i  input  8  write beats minus one.
REQ-009 SHALL have port axi_aw_size_i  input  3  log2 bytes per beat.
REQ-010 SHALL have port axi_aw_burst_i  input  2  FIXED=00, INCR=01, WRAP=10.
REQ-011 SHALL have port axi_aw_valid_i  input  1  AW valid.
REQ-012 SHALL have port axi_aw_ready_o  output  1  AW ready.
REQ-013 SHALL have port axi_w_data_i  input  DW  write data.
REQ-014 SHALL have port axi_w_strb_i  input  DW/8  byte strobes.
REQ-015 SHALL have port axi_w_last_i  input  1  last write beat flag.
REQ-016 SHALL have port axi_w_valid_i  input  1  W valid.
REQ-017 SHALL have port axi_w_ready_o  output  1  W ready.
REQ-018 SHALL have port axi_b_id_o  output  1  response ID.
REQ-019 SHALL have port axi_b_resp_o  output  2  OKAY=00, SLVERR=10.
REQ-020 SHALL have port axi_b_valid_o  output  1  B valid.
REQ-021 SHALL have port axi_b_ready_i  input  1  B ready.
REQ-022 SHALL have port axi_ar_id_i  input  1  read ID.
REQ-023 SHALL have port axi_ar_addr_i  input  AW  read start byte address.
REQ-024 SHALL have port axi_ar_len_i  input  8  read beats minus one.
REQ-025 SHALL have port axi_ar_size_i  input  3  log2 bytes per beat.
REQ-026 SHALL have port axi_ar_burst_i  input  2  burst type, encoding as AW.
REQ-027 SHALL have port axi_ar_valid_i  input  1  AR valid.
REQ-028 SHALL have port axi_ar_ready_o  output  1  AR ready.
REQ-029 SHALL have port axi_r_id_o  output  1  read ID.
REQ-030 SHALL have port axi_r_data_o  output  DW  read data.
REQ-031 SHALL have port axi_r_resp_o  output  2  read response, encoding as B.
REQ-032 SHALL have port axi_r_last_o  output  1  last read beat.
REQ-033 SHALL have port axi_r_valid_o  output  1  R valid.
REQ-034 SHALL have port axi_r_ready_i  input  1  R ready.

Function
REQ-035 Write FSM SHALL use states W_IDLE (aw_ready=1), W_DATA (w_ready=1), W_RESP (b_valid=1); AW handshake -> W_DATA; beat count==len handshake -> W_RESP; b handshake -> W_IDLE.
REQ-036 On AW handshake SHALL latch id/addr/len/size/burst and clear beat count; w_ready SHALL rise the next cycle; b_valid SHALL rise the cycle after the final W handshake.
REQ-037 Each W handshake SHALL write only strobed bytes to word (addr / (DW/8)) mod MEM_WORDS; an error burst (REQ-041) SHALL write nothing.
REQ-038 Read FSM SHALL use states R_IDLE (ar_ready=1), R_DATA (r_valid=1); r_valid SHALL rise the cycle after AR handshake; r_last=1 only on beat count==len; R_IDLE after last R handshake.
REQ-039 While r_valid=1 and r_ready=0, r_data/r_resp/r_last/r_id SHALL hold stable; r_data SHALL be 0 whenever r_valid=0; no combinational input-to-output paths.
REQ-040 Address step per beat: FIXED unchanged; INCR += 1<<size; WRAP += 1<<size, wrapping within the (len+1)<<size aligned window.
REQ-041 Response SHALL be SLVERR for the whole burst if burst=11, size>log2(DW/8), or WRAP with len not in {1,3,7,15}; SLVERR reads SHALL return data 0; else OKAY.
REQ-042 Final W beat with w_last=0, or w_last=1 on an earlier beat, SHALL make b_resp SLVERR; beat counting SHALL use len only; already-written beats remain.
REQ-043 Read and write FSMs SHALL run independently; same-cycle write beat and read beat to one word SHALL return the pre-write value.

Reset
REQ-044 HRESETn low SHALL immediately force all ready/valid/last/resp/id/data outputs to 0 and both FSMs to IDLE, abandoning any burst mid-operation; memory SHALL NOT be cleared; aw_ready and ar_ready SHALL be 1 in the first cycle after deassertion.

Verification
REQ-045 INCR write addr 0x10, len 3, size 3, data 1..4, strb 0xFF -> b_resp 00 one cycle after 4th beat; INCR read addr 0x10 len 3 -> 1,2,3,4, r_last on beat 4 only.
REQ-046 WRAP read addr 0x18, len 3, size 3 -> words at 0x18,0x00,0x08,0x10; WRAP len 2 -> four... three beats, all r_resp 10, data 0.
REQ-047 Write strb 0x0F data 0xFFFF_FFFF_FFFF_FFFF over word 0 -> readback 0x0000_0000_FFFF_FFFF; r_ready held low 5 cycles -> r_data stable throughout.
REQ-048 Write len 1 with w_last=0 on beat 2 -> b_resp 10; b_ready low 3 cycles -> b_valid held, aw_ready stays 0 until B handshake.
REQ-049 HRESETn pulsed low during beat 2 of a len-7 read -> r_valid 0 immediately, ar_ready 1 cycle after release, next read returns stored data.
